// File: rtl/timer_arbiter_if.sv
// Requester-side bundle for timer_arbiter: level requests and packed periods in,
// one-hot grant, done pulse, busy and owner index out.
interface timer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int N_BIT = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                     enable;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*N_BIT-1:0]   period;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic                     busy;
  logic [ID_W-1:0]          active_id;

  modport master (
    output enable, req, period,
    input  grant, done, busy, active_id
  );

  modport slave (
    input  enable, req, period,
    output grant, done, busy, active_id
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin shared down-counting delay timer: grants one requester, holds grant
// for period+1 enabled cycles, then pulses done. Optional TIMER_ARB_ABORT_EN lets a
// requester cancel its delay by dropping req.
module timer_arbiter #(
  parameter int N_BIT = 16,
  parameter int N_REQ = 4
) (
  input  logic            clkin,
  input  logic            rst_n,
  timer_arbiter_if.slave  bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [N_BIT-1:0] count, count_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  active_id, id_n;
  logic [N_REQ-1:0] grant, grant_n;
  logic [N_REQ-1:0] done, done_n;
  logic             busy;
  logic [ID_W-1:0]  win;
  logic             found;

  // Search starts just past the last winner so nobody wins twice while others wait.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    ptr_n   = ptr;
    id_n    = active_id;
    grant_n = grant;
    done_n  = '0;
    case (state)
      IDLE: begin
        if (bus.enable && found) begin
          state_n = COUNT;
          grant_n = N_REQ'(1) << win;
          id_n    = win;
          ptr_n   = win;
          count_n = bus.period[int'(win)*N_BIT +: N_BIT];
        end
      end
      COUNT: begin
`ifdef TIMER_ARB_ABORT_EN
        if (!bus.req[active_id]) begin
          state_n = IDLE;
          grant_n = '0;
          count_n = '0;
        end else
`endif
        if (bus.enable) begin
          if (count == '0) begin
            state_n           = DONE;
            grant_n           = '0;
            done_n[active_id] = 1'b1;
          end else begin
            count_n = count - N_BIT'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      ptr       <= ID_W'(N_REQ - 1);
      active_id <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      ptr       <= ptr_n;
      active_id <= id_n;
      grant     <= grant_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
    end
  end

  assign bus.grant     = grant;
  assign bus.done      = done;
  assign bus.busy      = busy;
  assign bus.active_id = active_id;
endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: table of delay transactions plus hand-written
// reset-mid-count and req-drop sequences.
module tb_timer_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  timer_arbiter_if #(.N_REQ(4), .N_BIT(16)) bus ();

  timer_arbiter #(.N_BIT(16), .N_REQ(4)) dut (
    .clkin (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] per;
    bit          rst;
    int          stall_at;
    int          stall_len;
    bit          chg;
    int          id;
    int          w;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a sample where grant is expected high; follows it to done and idle.
  task automatic finish_delay(input int id, input int exp_w, input int stall_at,
                              input int stall_len, input bit chg);
    int w;
    int bad;
    logic [3:0] oh;
    w   = 0;
    bad = 0;
    oh  = 4'b0001 << id;
    while (bus.grant != 4'b0 && w < 70000) begin
      w++;
      if (bus.grant !== oh || bus.busy !== 1'b1 || int'(bus.active_id) != id) bad++;
      if (stall_len > 0 && w == stall_at) bus.enable = 1'b0;
      if (stall_len > 0 && w == stall_at + stall_len) bus.enable = 1'b1;
      if (chg && w == 2) bus.period = {4{16'd1}};
      @(negedge clk);
    end
    bus.enable = 1'b1;
    chk("grant_hold", 32'(bad), 32'd0);
    chk("grant_width", 32'(w), 32'(exp_w));
    chk("grant_clear", 32'(bus.grant), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'(oh));
    chk("busy_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("done_clear", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("id_keep", 32'(bus.active_id), 32'(id));
  endtask

  task automatic run_delay(input int id, input int exp_w, input int stall_at,
                           input int stall_len, input bit chg);
    @(negedge clk);
    chk("grant_start", 32'(bus.grant), 32'(4'b0001 << id));
    if (bus.grant != 4'b0) finish_delay(id, exp_w, stall_at, stall_len, chg);
  endtask

  initial begin
    logic [3:0] seen;
    // req, period, reset-first, stall_at, stall_len, period-change, winner, width
    tbl[0]  = '{4'b0001, 16'd5,     1'b0, 0, 0, 1'b0, 0, 6};
    tbl[1]  = '{4'b1111, 16'd2,     1'b1, 0, 0, 1'b0, 0, 3};
    tbl[2]  = '{4'b1111, 16'd2,     1'b0, 0, 0, 1'b0, 1, 3};
    tbl[3]  = '{4'b1111, 16'd2,     1'b0, 0, 0, 1'b0, 2, 3};
    tbl[4]  = '{4'b1111, 16'd2,     1'b0, 0, 0, 1'b0, 3, 3};
    tbl[5]  = '{4'b1111, 16'd2,     1'b0, 0, 0, 1'b0, 0, 3};
    tbl[6]  = '{4'b0100, 16'd3,     1'b0, 2, 4, 1'b0, 2, 8};
    tbl[7]  = '{4'b1000, 16'd0,     1'b0, 0, 0, 1'b0, 3, 1};
    tbl[8]  = '{4'b0011, 16'd1,     1'b0, 0, 0, 1'b0, 0, 2};
    tbl[9]  = '{4'b0011, 16'd1,     1'b0, 0, 0, 1'b0, 1, 2};
    tbl[10] = '{4'b0011, 16'd1,     1'b0, 0, 0, 1'b0, 0, 2};
    tbl[11] = '{4'b0010, 16'd4,     1'b0, 0, 0, 1'b1, 1, 5};
    tbl[12] = '{4'b0001, 16'hFFFF,  1'b0, 0, 0, 1'b0, 0, 65536};

    bus.enable = 1'b1;
    bus.req    = '0;
    bus.period = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_id", 32'(bus.active_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      bus.req    = tbl[i].req;
      bus.period = {4{tbl[i].per}};
      run_delay(tbl[i].id, tbl[i].w, tbl[i].stall_at, tbl[i].stall_len, tbl[i].chg);
    end

    // Reset mid-count: winner 2 (search from ptr 0), pulled at count==2.
    bus.req    = 4'b0100;
    bus.period = {4{16'd5}};
    @(negedge clk);
    chk("mid_grant", 32'(bus.grant), 32'b0100);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_done", 32'(bus.done), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.req = '0;
    rst_n   = 1'b1;
    seen    = '0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    // Pointer back at N_REQ-1, so req[0] beats req[3].
    bus.req    = 4'b1001;
    bus.period = {4{16'd2}};
    run_delay(0, 3, 0, 0, 1'b0);

    // req[1] drops one cycle into its delay while req[2] waits.
    bus.req    = 4'b0110;
    bus.period = {4{16'd3}};
    @(negedge clk);
    chk("drop_grant1", 32'(bus.grant), 32'b0010);
    bus.req = 4'b0100;
`ifdef TIMER_ARB_ABORT_EN
    @(negedge clk);
    chk("abort_grant", 32'(bus.grant), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("abort_next", 32'(bus.grant), 32'b0100);
    if (bus.grant != 4'b0) finish_delay(2, 4, 0, 0, 1'b0);
`else
    finish_delay(1, 4, 0, 0, 1'b0);
    run_delay(2, 4, 0, 0, 1'b0);
`endif
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
